// File: rtl/matrix_result_sequencer_if.sv
// Result-stream interface for matrix_result_sequencer.
// The producer (master) drives one row-major result word per handshake. The consumer
// (slave) drives out_ready.
//   out_data  : 32-bit result word
//   out_idx   : element index 0..8 (0=d11 ... 8=d33)
//   out_valid : out_data/out_idx/out_last are valid
//   out_ready : consumer accepts the current word
//   out_last  : high together with idx 8
interface matrix_result_sequencer_if;
    logic [31:0] out_data;
    logic [3:0]  out_idx;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    modport master (
        output out_data,
        output out_idx,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_idx,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/matrix_result_sequencer.sv
// Run/capture/readout controller placed beside the single-cycle MIPS core.
// It steps the core's PC from START_PC to HALT_PC and then holds the PC at HALT_PC. After a
// settle period it snapshots the nine 3x3 result words and streams them row-major.
// Ports:
//   clk, rst_n      : clock and synchronous active-low reset
//   start_i         : begin a run (sampled only in idle)
//   pc_out_o        : PC driven into the core
//   d11_i .. d33_i  : result matrix from the core
//   out_if          : valid/ready result stream (master side)
//   busy_o          : high in run, settle, capture and stream
//   done_o          : one-cycle pulse after the final word is accepted
module matrix_result_sequencer #(
    parameter logic [31:0] START_PC      = 32'hFFFF_FFFC,
    parameter logic [31:0] HALT_PC       = 32'd356,
    parameter logic [31:0] STEP          = 32'd4,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start_i,
    output logic [31:0]                       pc_out_o,
    input  logic [31:0]                       d11_i,
    input  logic [31:0]                       d12_i,
    input  logic [31:0]                       d13_i,
    input  logic [31:0]                       d21_i,
    input  logic [31:0]                       d22_i,
    input  logic [31:0]                       d23_i,
    input  logic [31:0]                       d31_i,
    input  logic [31:0]                       d32_i,
    input  logic [31:0]                       d33_i,
    matrix_result_sequencer_if.master         out_if,
    output logic                              busy_o,
    output logic                              done_o
);

    localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] LastIdx    = 4'd8;

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StSettle,
        StCapture,
        StStream,
        StDone
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] data_q;
    logic [3:0]  idx_q;
    logic [3:0]  settle_q;
    logic        valid_q;
    logic        last_q;
    logic        done_q;
    logic [31:0] snap_q [9];

    logic [31:0] pc_next;
    logic [3:0]  idx_next;

    assign pc_next  = pc_q + STEP;
    assign idx_next = idx_q + 4'd1;

    // Snapshot is deliberately not reset; it is only ever read after a capture.
    always_ff @(posedge clk) begin
        if (state_q == StCapture) begin
            snap_q[0] <= d11_i;
            snap_q[1] <= d12_i;
            snap_q[2] <= d13_i;
            snap_q[3] <= d21_i;
            snap_q[4] <= d22_i;
            snap_q[5] <= d23_i;
            snap_q[6] <= d31_i;
            snap_q[7] <= d32_i;
            snap_q[8] <= d33_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            pc_q     <= START_PC;
            data_q   <= '0;
            idx_q    <= '0;
            settle_q <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    pc_q <= START_PC;
                    if (start_i) begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    pc_q <= pc_next;
                    if (pc_next == HALT_PC) begin
                        state_q  <= StSettle;
                        settle_q <= '0;
                    end
                end
                StSettle: begin
                    if (settle_q == SettleLast) begin
                        state_q  <= StCapture;
                        settle_q <= '0;
                    end else begin
                        settle_q <= settle_q + 4'd1;
                    end
                end
                StCapture: begin
                    // The first word comes straight from the input being captured this edge.
                    state_q <= StStream;
                    idx_q   <= '0;
                    data_q  <= d11_i;
                    valid_q <= 1'b1;
                    last_q  <= 1'b0;
                end
                StStream: begin
                    if (valid_q && out_if.out_ready) begin
                        if (idx_q == LastIdx) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            idx_q  <= idx_next;
                            data_q <= snap_q[idx_next];
                            last_q <= (idx_next == LastIdx);
                        end
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    pc_q    <= START_PC;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign pc_out_o         = pc_q;
    assign out_if.out_data  = data_q;
    assign out_if.out_idx   = idx_q;
    assign out_if.out_valid = valid_q;
    assign out_if.out_last  = last_q;
    assign done_o           = done_q;
    assign busy_o           = (state_q == StRun) || (state_q == StSettle) ||
                              (state_q == StCapture) || (state_q == StStream);

endmodule

// File: tb/tb_matrix_result_sequencer.sv
// Bench for matrix_result_sequencer: a table of runs (matrix values, ready pattern, corner
// options, expected timing) checked against a transaction-level model of one run.
module tb_matrix_result_sequencer;

    localparam logic [31:0] START_PC = 32'hFFFF_FFFC;
    localparam logic [31:0] HALT_PC  = 32'd356;
    localparam logic [31:0] STEP     = 32'd4;
    localparam int          SETTLE   = 2;

    typedef struct packed {
        logic [8:0][31:0] d;
        int               mode;       // 0: ready always, 1: ready 1,0,0,..., 2: random ready
        bit               iso;        // overwrite d inputs once streaming starts
        bit               poke;       // pulse start while busy
        bit               rst_mid;    // reset after idx 4 is accepted
        int               exp_first;  // cycle after start edge where out_valid first shows
        int               exp_done;   // cycle of the done pulse, -1 when ready-dependent
    } vec_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  idx;
        logic        last;
    } word_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] pc_out;
    logic [31:0] dv [9];
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    matrix_result_sequencer_if sif ();

    matrix_result_sequencer #(
        .START_PC      (START_PC),
        .HALT_PC       (HALT_PC),
        .STEP          (STEP),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start),
        .pc_out_o (pc_out),
        .d11_i    (dv[0]),
        .d12_i    (dv[1]),
        .d13_i    (dv[2]),
        .d21_i    (dv[3]),
        .d22_i    (dv[4]),
        .d23_i    (dv[5]),
        .d31_i    (dv[6]),
        .d32_i    (dv[7]),
        .d33_i    (dv[8]),
        .out_if   (sif.master),
        .busy_o   (busy),
        .done_o   (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model of one run: PC ramps from START_PC by STEP until HALT_PC, holds there, and the
    // nine values present at capture come out in row-major order, one per handshake.
    task automatic run_case(input int n, input vec_t v);
        word_t       got[$];
        logic [31:0] diff;
        logic [31:0] exp_pc;
        logic [31:0] pd;
        logic [3:0]  pi;
        logic        pl;
        int          nrun;
        int          cyc = 0;
        int          first_valid = -1;
        int          done_cyc = -1;
        int          last_hs = -1;
        int          pc_bad = 0;
        int          busy_bad = 0;
        int          hold_bad = 0;
        int          done_cnt = 0;
        bit          prev_stall = 1'b0;
        bit          rdy;
        bit          finished = 1'b0;
        string       tag;

        tag  = $sformatf("run%0d", n);
        diff = HALT_PC - START_PC;
        nrun = int'(diff / STEP);
        for (int i = 0; i < 9; i++) dv[i] = v.d[i];
        start = 1'b1;
        tick();  // start edge E
        start = 1'b0;

        while (!finished && cyc < 400) begin
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                chk({tag, "_idle_pc"}, pc_out, START_PC);
                chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
                chk({tag, "_done_width"}, 32'(done), 32'd0);
                finished = 1'b1;
                break;
            end
            exp_pc = (cyc <= nrun) ? START_PC + STEP * 32'(cyc) : HALT_PC;
            if (pc_out !== exp_pc) pc_bad++;
            if (sif.out_valid && first_valid < 0) begin
                first_valid = cyc;
                if (v.iso) for (int i = 0; i < 9; i++) dv[i] = 32'hDEAD_BEEF;
            end
            if (prev_stall && (!sif.out_valid || sif.out_data !== pd || sif.out_idx !== pi ||
                               sif.out_last !== pl)) begin
                hold_bad++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
                chk({tag, "_valid_at_done"}, 32'(sif.out_valid), 32'd0);
            end else if (!busy) begin
                busy_bad++;
            end
            if (v.rst_mid && got.size() == 5 && cyc == last_hs + 1) begin
                chk({tag, "_idx_before_rst"}, 32'(sif.out_idx), 32'd5);
                rst_n         = 1'b0;
                sif.out_ready = 1'b0;
                tick();
                chk({tag, "_rst_valid"}, 32'(sif.out_valid), 32'd0);
                chk({tag, "_rst_pc"}, pc_out, START_PC);
                chk({tag, "_rst_busy"}, 32'(busy), 32'd0);
                chk({tag, "_rst_idx"}, 32'(sif.out_idx), 32'd0);
                rst_n = 1'b1;
                return;
            end
            start = v.poke && (cyc == 19 || (first_valid >= 0 && cyc == first_valid + 2));
            case (v.mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            sif.out_ready = rdy;
            if (sif.out_valid && rdy) begin
                got.push_back('{data: sif.out_data, idx: sif.out_idx, last: sif.out_last});
                last_hs = cyc;
            end
            prev_stall = sif.out_valid && !rdy;
            pd = sif.out_data;
            pi = sif.out_idx;
            pl = sif.out_last;
            tick();
            cyc++;
        end
        start = 1'b0;

        chk({tag, "_finished"}, 32'(finished), 32'd1);
        chk({tag, "_pc_trace_errs"}, 32'(pc_bad), 32'd0);
        chk({tag, "_busy_trace_errs"}, 32'(busy_bad), 32'd0);
        chk({tag, "_hold_errs"}, 32'(hold_bad), 32'd0);
        chk({tag, "_first_valid"}, 32'(first_valid), 32'(v.exp_first));
        chk({tag, "_done_after_last"}, 32'(done_cyc), 32'(last_hs + 1));
        chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        if (v.exp_done >= 0) chk({tag, "_done_cycle"}, 32'(done_cyc), 32'(v.exp_done));
        chk({tag, "_word_count"}, 32'(got.size()), 32'd9);
        for (int i = 0; i < 9 && i < got.size(); i++) begin
            chk($sformatf("%s_w%0d_data", tag, i), got[i].data, v.d[i]);
            chk($sformatf("%s_w%0d_idx", tag, i), 32'(got[i].idx), 32'(i));
            chk($sformatf("%s_w%0d_last", tag, i), 32'(got[i].last), 32'(i == 8));
        end
    endtask

    initial begin
        vec_t        tbl[8];
        logic [31:0] cst[9];

        cst = '{32'd30, 32'd24, 32'd18, 32'd84, 32'd69, 32'd54, 32'd138, 32'd114, 32'd90};
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 9; i++) tbl[k].d[i] = (k < 5) ? cst[i] : $urandom;
            tbl[k].mode      = 0;
            tbl[k].iso       = 1'b0;
            tbl[k].poke      = 1'b0;
            tbl[k].rst_mid   = 1'b0;
            tbl[k].exp_first = 93;
            tbl[k].exp_done  = 102;
        end
        tbl[1].mode     = 1;  tbl[1].exp_done = -1;
        tbl[2].iso      = 1'b1;
        tbl[3].poke     = 1'b1;
        tbl[4].rst_mid  = 1'b1;
        tbl[5].mode     = 2;  tbl[5].iso = 1'b1; tbl[5].exp_done = -1;
        tbl[6].mode     = 2;  tbl[6].poke = 1'b1; tbl[6].exp_done = -1;
        tbl[7].mode     = 1;  tbl[7].iso = 1'b1; tbl[7].exp_done = -1;

        for (int i = 0; i < 9; i++) dv[i] = 32'd0;
        sif.out_ready = 1'b0;
        rst_n = 1'b0;
        start = 1'b0;
        tick();
        tick();
        chk("reset_pc", pc_out, START_PC);
        chk("reset_valid", 32'(sif.out_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_last", 32'(sif.out_last), 32'd0);
        chk("reset_idx", 32'(sif.out_idx), 32'd0);
        chk("reset_data", sif.out_data, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_holds_pc", pc_out, START_PC);

        for (int k = 0; k < 8; k++) run_case(k, tbl[k]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
